// File: rtl/norm_round_ctrl.sv
// norm_round_ctrl: multi-cycle normalize-and-round sequencer for the FP result path.
// Takes sign / biased exponent / 28-bit extended mantissa, normalizes one bit per
// cycle and rounds on the 4 guard bits. It returns a single-precision exponent,
// a fraction and status flags.
// Optional build macro: ROUND_RNE_EN selects round-to-nearest-even.
// When it is undefined, the block rounds half-up.
//
// Handshake rule on both sides: a transfer happens on the rising clock edge where
// valid and ready are both high. The producer holds valid and data stable until
// that edge. in_ready is high only in IDLE. out_valid is high only in DONE.
//
// Output fraction: the hidden one at M[26] is dropped. The 22 extended fraction
// bits M[25:4] sit in out_mantis[21:0], and out_mantis[22] is always zero.
module norm_round_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] in_mantis,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [7:0]  out_exp,
  output logic [22:0] out_mantis,
  output logic        out_ovf,
  output logic        out_uf,
  output logic        out_inexact
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // state_q is the FSM state that checkers bind to
  state_t      state_q, state_d;
  logic        sign_q;
  logic [8:0]  exp_q;   // 9 bits so 255+1 and 256+1 never wrap
  logic [27:0] man_q;

  logic        in_zero;
  logic        norm_carry, norm_hidden, norm_flush;
  logic        round_inc, round_ovf, round_inexact;
  logic [23:0] round_sum;
  logic [21:0] round_frac;
  logic [8:0]  round_exp;

  assign in_zero     = (in_mantis == 28'd0);
  assign norm_carry  = man_q[27];
  assign norm_hidden = man_q[26];
  assign norm_flush  = (exp_q <= 9'd1);

  // Round step: the increment lands on the ulp (bit 4); a carry out renormalizes by one
  always_comb begin
`ifdef ROUND_RNE_EN
    round_inc = man_q[3] & ((|man_q[2:0]) | man_q[4]);
`else
    round_inc = man_q[3];
`endif
    round_sum     = man_q[27:4] + {23'd0, round_inc};
    round_inexact = |man_q[3:0];
    if (round_sum[23]) begin
      round_frac = round_sum[22:1];
      round_exp  = exp_q + 9'd1;
    end else begin
      round_frac = round_sum[21:0];
      round_exp  = exp_q;
    end
    round_ovf = (round_exp >= 9'd255);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = in_zero ? S_DONE : S_NORM;
      S_NORM: begin
        if (norm_carry || norm_hidden) state_d = S_ROUND;
        else if (norm_flush)           state_d = S_DONE;
      end
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Working registers and result registers; results load only on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q      <= 1'b0;
      exp_q       <= 9'd0;
      man_q       <= 28'd0;
      out_sign    <= 1'b0;
      out_exp     <= 8'd0;
      out_mantis  <= 23'd0;
      out_ovf     <= 1'b0;
      out_uf      <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sign_q <= in_sign;
            exp_q  <= {1'b0, in_exp};
            man_q  <= in_mantis;
            if (in_zero) begin
              out_sign    <= in_sign;
              out_exp     <= 8'd0;
              out_mantis  <= 23'd0;
              out_ovf     <= 1'b0;
              out_uf      <= 1'b0;
              out_inexact <= 1'b0;
            end
          end
        end
        S_NORM: begin
          if (norm_carry) begin
            // right shift keeps the dropped bit as sticky in bit 0
            man_q <= {1'b0, man_q[27:2], man_q[1] | man_q[0]};
            exp_q <= exp_q + 9'd1;
          end else if (norm_hidden) begin
            man_q <= man_q;
          end else if (norm_flush) begin
            out_sign    <= sign_q;
            out_exp     <= 8'd0;
            out_mantis  <= 23'd0;
            out_ovf     <= 1'b0;
            out_uf      <= 1'b1;
            out_inexact <= 1'b1;
          end else begin
            man_q <= {man_q[26:0], 1'b0};
            exp_q <= exp_q - 9'd1;
          end
        end
        S_ROUND: begin
          out_sign    <= sign_q;
          out_uf      <= 1'b0;
          out_inexact <= round_inexact;
          if (round_ovf) begin
            out_exp    <= 8'hFF;
            out_mantis <= 23'd0;
            out_ovf    <= 1'b1;
          end else begin
            out_exp    <= round_exp[7:0];
            out_mantis <= {1'b0, round_frac};
            out_ovf    <= 1'b0;
          end
        end
        default: begin
          man_q <= man_q;
        end
      endcase
    end
  end

endmodule
